div_sequencer: RTL and testbench
================================

# div_sequencer

Multi-cycle radix-2 divide unit with its own sequencing FSM, serving DIV/DIVU in the execute stage of the 5-stage MIPS pipeline. It accepts operands when the controller raises `start`, and holds the execute stage with `stall` for the duration. It produces `{hi, lo} = {remainder, quotient}` for the HI/LO write path, and accepts a synchronous `cancel` from the flush logic.

## Interface
- `WIDTH`, 32: operand width; the iteration counter is sized to `$clog2(WIDTH)` bits.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  DIV/DIVU present in E; held high by the pipeline until `ready`.
- `signed_div`  in  1  1 = DIV (signed), 0 = DIVU.
- `a`  in  WIDTH  dividend (rs value, after forwarding).
- `b`  in  WIDTH  divisor (rt value, after forwarding).
- `cancel`  in  1  flushE/exception; aborts any operation in progress.
- `stall`  out  1  combinational: `start & ~ready`.
- `ready`  out  1  registered; high for exactly one cycle, in DONE.
- `hi`  out  WIDTH  remainder; registered, held until the next accepted start.
- `lo`  out  WIDTH  quotient; registered, held until the next accepted start.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - If `start & ~cancel`, latch `|a|` and `|b|` (absolute values only when `signed_div`), the quotient sign `a[31]^b[31]`, and the remainder sign `a[31]`.
  - If `b != 0`, clear the counter and go to RUN.
  - If `b == 0`, go to DONE with `lo = 32'hFFFF_FFFF` and `hi = a`, regardless of sign mode.
- **RUN:** one restoring step per cycle.
  - Shift `{rem, quo}` left by 1.
  - If `rem >= divisor`, subtract `divisor` from `rem` and set the quotient LSB.
  - After 32 steps (counter reaches 31), go to DONE.
- **DONE:**
  - `ready = 1`.
  - The sign-corrected results are already in `hi`/`lo`; they are loaded on the RUN→DONE edge.
  - Next state is IDLE unconditionally.
- **Sign fix (signed mode):**
  - Negate the quotient when the quotient sign is 1.
  - Negate the remainder when the remainder sign is 1.
  - `32'h8000_0000 / -1` yields `lo = 32'h8000_0000`, `hi = 0`.
- **`cancel`:**
  - Highest priority in every state: next state is IDLE.
  - `ready` is not raised.
  - `hi`/`lo` keep their previous values.
  - Operands presented with `start` and `cancel` in the same cycle are not accepted.
- **Operand changes:** `a`, `b` and `signed_div` are ignored outside the IDLE acceptance cycle.
- **Back-to-back:** a new `start` in the first IDLE cycle after DONE is accepted normally. The pipeline drops `start` after `ready` unless a new divide has entered E.
- **Reset (`rst` low, any time, including mid-RUN):**
  - State goes to IDLE, counter to 0, `ready` to 0, `hi`/`lo` to 0.
  - `stall` then equals `start`.

## Timing
- Cycle 0: `start` seen in IDLE; `stall = 1`.
- Cycles 1–32: RUN; `stall = 1`.
- Cycle 33: DONE; `ready = 1`, `stall = 0`, `hi`/`lo` valid. E advances on the cycle-33 edge.
- Divide-by-zero: `ready` in cycle 1, so the stall lasts 1 cycle.
- `cancel` asserted in cycle k: state is IDLE in cycle k+1, and `stall` follows the new `start` value.
- The critical path is one WIDTH+1-bit subtract plus a mux per cycle; no multi-cycle paths.

## Test plan
- **Unsigned divide:** DIVU `a=100`, `b=7` at cycle 0 → `stall` high cycles 0–32; cycle 33 `ready=1`, `lo=14`, `hi=2`.
- **Signed divide:** DIV `a=-7` (`0xFFFFFFF9`), `b=2` → `lo=0xFFFFFFFD` (-3), `hi=0xFFFFFFFF` (-1).
- **Signed overflow case:** DIV `a=0x80000000`, `b=0xFFFFFFFF` → `lo=0x80000000`, `hi=0`.
- **Divide by zero and back-to-back:** DIVU `a=0x1234`, `b=0` → `ready` at cycle 1, `lo=0xFFFFFFFF`, `hi=0x1234`. Immediately follow with DIVU `a=9`, `b=3` → `ready` 33 cycles after acceptance, `lo=3`, `hi=0`.
- **Cancel mid-operation:** start DIVU 50/5, assert `cancel` at cycle 10.
  - Cycle 11: IDLE, no `ready` ever raised, `hi`/`lo` unchanged from the prior result.
  - A new start of 50/5 then completes with `lo=10`, `hi=0`.
- **Reset mid-operation:** pull `rst` low at cycle 20 of a divide → `ready=0`, `hi=lo=0`, `stall=start` immediately. After release, a new divide completes with the full 33-cycle stall.

Source files
------------

// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
// Produces {hi, lo} = {remainder, quotient}, stalls E while busy, and honours a flush-driven cancel.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             stall,
  output logic             ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CNT_W-1:0] r_cnt;
  logic             r_ready;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic             r_qneg;
  logic             r_rneg;

  logic             w_accept;
  logic             w_b_zero;
  logic             w_last;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_sub;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  assign w_accept = (r_state == IDLE) && start && !cancel;
  assign w_b_zero = (b == '0);
  assign w_last   = (r_state == RUN) && (r_cnt == LAST_STEP);

  assign w_a_abs = cond_neg(a, signed_div & a[WIDTH-1]);
  assign w_b_abs = cond_neg(b, signed_div & b[WIDTH-1]);

  // The borrow out of the WIDTH+1-bit subtract doubles as the "rem < divisor" flag.
  assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
  assign w_sub    = w_rem_sh - {1'b0, r_div};
  assign w_ge     = ~w_sub[WIDTH];
  assign w_rem_nx = w_ge ? w_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_quo_nx = {r_quo[WIDTH-2:0], w_ge};

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = w_b_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (r_cnt == LAST_STEP) begin
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (cancel) begin
      w_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == DONE);
      if (w_accept) begin
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      // Results only move on a real completion; a cancelled divide leaves the old pair intact.
      if (w_accept && w_b_zero) begin
        r_hi <= a;
        r_lo <= '1;
      end else if (w_last && !cancel) begin
        r_hi <= cond_neg(w_rem_nx, r_rneg);
        r_lo <= cond_neg(w_quo_nx, r_qneg);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rem  <= '0;
      r_quo  <= w_a_abs;
      r_div  <= w_b_abs;
      r_qneg <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
      r_rneg <= signed_div & a[WIDTH-1];
    end else if (r_state == RUN) begin
      r_rem <= w_rem_nx;
      r_quo <= w_quo_nx;
    end
  end

  assign stall = start & ~r_ready;
  assign ready = r_ready;
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: unsigned/signed divides, overflow, divide-by-zero,
// back-to-back issue, cancel and asynchronous reset mid-operation.
module tb_div_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        stall;
  logic        ready;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks;
  int n_fail;

  div_sequencer #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_div(signed_div),
    .a         (a),
    .b         (b),
    .cancel    (cancel),
    .stall     (stall),
    .ready     (ready),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the cycle after DONE.
  task automatic do_div(input logic sd, input logic [31:0] av, input logic [31:0] bv,
                        input int exp_lat, input logic [31:0] elo, input logic [31:0] ehi,
                        input string tag);
    int n;
    int n_stall;
    n = 0;
    n_stall = 0;
    start = 1'b1;
    signed_div = sd;
    a = av;
    b = bv;
    @(negedge clk);
    while (!ready && n < 40) begin
      if (stall) n_stall++;
      n++;
      tick();
      a = $urandom;
      b = $urandom;
      signed_div = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    chk({tag, ".latency"}, 32'(n), 32'(exp_lat));
    chk({tag, ".stall_cycles"}, 32'(n_stall), 32'(exp_lat));
    chk({tag, ".stall_at_ready"}, 32'(stall), 32'd0);
    chk({tag, ".lo"}, lo, elo);
    chk({tag, ".hi"}, hi, ehi);
    tick();
    start = 1'b0;
  endtask

  initial begin
    int seen;
    n_checks = 0;
    n_fail = 0;
    rst = 1'b0;
    start = 1'b0;
    signed_div = 1'b0;
    a = '0;
    b = '0;
    cancel = 1'b0;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    chk("rst.ready", 32'(ready), 32'd0);
    chk("rst.hi", hi, 32'd0);
    chk("rst.lo", lo, 32'd0);
    chk("rst.stall_lo", 32'(stall), 32'd0);
    start = 1'b1;
    #1;
    chk("rst.stall_eq_start", 32'(stall), 32'd1);
    tick();
    start = 1'b0;
    rst = 1'b1;
    tick();

    do_div(1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, "divu_100_7");
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div_m7_2");
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1, "div_7_m2");
    do_div(1'b0, 32'hFFFF_FFF9, 32'd2, 33, 32'h7FFF_FFFC, 32'd1, "divu_big_2");
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0, "div_ovf");
    do_div(1'b1, 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, "div_m5_0");

    // Divide by zero immediately followed by a normal divide
    do_div(1'b0, 32'h0000_1234, 32'd0, 1, 32'hFFFF_FFFF, 32'h0000_1234, "divu_zero");
    do_div(1'b0, 32'd9, 32'd3, 33, 32'd3, 32'd0, "divu_b2b");

    // Cancel at cycle 10 of a 50/5 divide
    start = 1'b1;
    signed_div = 1'b0;
    a = 32'd50;
    b = 32'd5;
    for (int i = 0; i < 10; i++) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("cancel.ready", 32'(ready), 32'd0);
    chk("cancel.stall", 32'(stall), 32'd0);
    chk("cancel.lo_kept", lo, 32'd3);
    chk("cancel.hi_kept", hi, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) seen++;
    end
    chk("cancel.no_ready", 32'(seen), 32'd0);
    tick();
    do_div(1'b0, 32'd50, 32'd5, 33, 32'd10, 32'd0, "divu_50_5");

    // start and cancel together in IDLE must not be accepted
    start = 1'b1;
    cancel = 1'b1;
    a = 32'd77;
    b = 32'd0;
    tick();
    start = 1'b0;
    cancel = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) seen++;
    end
    chk("start_cancel.no_ready", 32'(seen), 32'd0);
    chk("start_cancel.lo_kept", lo, 32'd10);
    tick();

    // Asynchronous reset at cycle 20 of a divide
    start = 1'b1;
    signed_div = 1'b0;
    a = 32'd1000;
    b = 32'd3;
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b0;
    #1;
    chk("rstmid.ready", 32'(ready), 32'd0);
    chk("rstmid.hi", hi, 32'd0);
    chk("rstmid.lo", lo, 32'd0);
    chk("rstmid.stall_eq_start", 32'(stall), 32'd1);
    start = 1'b0;
    #1;
    chk("rstmid.stall_follows", 32'(stall), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    do_div(1'b0, 32'd1000, 32'd3, 33, 32'd333, 32'd1, "divu_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
